// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline constants and the write-back result select encoding.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;
endpackage

// File: rtl/regfile_32x32.sv
// regfile_32x32: architectural register file, one write port, two combinational read ports, x0 hardwired to zero.
// Same-cycle write-to-read bypass is built in when WRITEBACK_BYPASS_EN is defined.
module regfile_32x32
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] wa_i,
    input  logic [XLEN-1:0]       wd_i,
    input  logic [REG_ADDR_W-1:0] a1_i,
    input  logic [REG_ADDR_W-1:0] a2_i,
    output logic [XLEN-1:0]       rd1_o,
    output logic [XLEN-1:0]       rd2_o
);
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_en;
    logic [XLEN-1:0] st1, st2;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wa_i] <= wd_i;
        end
    end

    assign st1 = (a1_i == '0) ? '0 : mem[a1_i];
    assign st2 = (a2_i == '0) ? '0 : mem[a2_i];

`ifdef WRITEBACK_BYPASS_EN
    // wr_en already excludes x0, so x0 is never forwarded
    assign rd1_o = (wr_en && a1_i == wa_i) ? wd_i : st1;
    assign rd2_o = (wr_en && a2_i == wa_i) ? wd_i : st2;
`else
    assign rd1_o = st1;
    assign rd2_o = st2;
`endif
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: WB result select, register file commit and committed-write counter.
// Optional same-cycle read bypass is enabled by defining WRITEBACK_BYPASS_EN.
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  regwritew_i,
    input  logic [1:0]            resultsrcw_i,
    input  logic [XLEN-1:0]       readdataw_i,
    input  logic [XLEN-1:0]       aluresultw_i,
    input  logic [XLEN-1:0]       pcplus4w_i,
    input  logic [REG_ADDR_W-1:0] rdw_i,
    input  logic [REG_ADDR_W-1:0] a1_i,
    input  logic [REG_ADDR_W-1:0] a2_i,
    output logic [XLEN-1:0]       rd1_o,
    output logic [XLEN-1:0]       rd2_o,
    output logic [XLEN-1:0]       resultw_o,
    output logic [31:0]           wbcount_o
);
    result_src_e src;
    logic        commit;

    assign src    = result_src_e'(resultsrcw_i);
    assign commit = regwritew_i && (rdw_i != '0);

    // encoding 2'b11 is reserved and yields zero
    always_comb begin
        resultw_o = (src == RES_ALU) ? aluresultw_i :
                    (src == RES_MEM) ? readdataw_i  :
                    (src == RES_PC4) ? pcplus4w_i   : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) wbcount_o <= '0;
        else if (commit) wbcount_o <= wbcount_o + 32'd1;
    end

    regfile_32x32 #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (regwritew_i),
        .wa_i    (rdw_i),
        .wd_i    (resultw_o),
        .a1_i    (a1_i),
        .a2_i    (a2_i),
        .rd1_o   (rd1_o),
        .rd2_o   (rd2_o)
    );
endmodule
